stream_pattern_gen: RTL

Parametrised multi-channel stream pattern generator. It drives a `stream_if` interface instance through its `master` modport, issuing one fixed-length burst per channel in round-robin order after a start pulse. It is the next-generation generator block: width, channel count and burst depth are generic, and it adds a valid/ready handshake, pattern modes and completion status. It sits at the top of elaboration and simulation benches as the stimulus source for interface-connected DUTs.

---
 rtl/stream_gen_pkg.sv | 34 +++
 rtl/stream_if.sv | 17 +
 rtl/stream_pattern_lfsr.sv | 22 ++
 rtl/stream_pattern_gen.sv | 111 +++++++++++
 4 files changed

// File: rtl/stream_gen_pkg.sv
// Shared types, LFSR taps and next-state function for the stream pattern generator.
// Pure declarations; no latency or flow control of its own.
package stream_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam logic [7:0]  LFSR_TAPS_W8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_W16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_W32 = 32'h80200003;

  function automatic logic [31:0] lfsr_taps(input int w);
    if (w == 8)       return {24'd0, LFSR_TAPS_W8};
    else if (w == 16) return {16'd0, LFSR_TAPS_W16};
    else              return LFSR_TAPS_W32;
  endfunction

  // Right-shifting Galois step; the state sits in the low w bits.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int w);
    if (s[0]) return (s >> 1) ^ lfsr_taps(w);
    else      return s >> 1;
  endfunction

endpackage

// File: rtl/stream_if.sv
// Valid/ready stream carrying data, channel index and end-of-burst marker.
// Beat transfers when valid and ready are both high at a rising edge.
interface stream_if #(
  parameter int W  = 8,
  parameter int CH = 4
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic          valid;
  logic          ready;
  logic [W-1:0]  data;
  logic [CW-1:0] chan;
  logic          last;

  modport master(output valid, output data, output chan, output last, input ready);
  modport slave (input valid, input data, input chan, input last, output ready);
endinterface

// File: rtl/stream_pattern_lfsr.sv
// W-bit Galois LFSR: load takes priority over advance; state updates the cycle after either.
// No flow control; the caller gates advance with beat acceptance.
module stream_pattern_lfsr
  import stream_gen_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [W-1:0] SEED = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          value <= SEED;
    else if (load)    value <= SEED;
    else if (advance) value <= W'(lfsr_next(32'(value), W));
  end

endmodule

// File: rtl/stream_pattern_gen.sv
// Round-robin burst generator: first beat 1 cycle after start, beat held stable under backpressure.
// LFSR pattern compiled only when STREAM_PATTERN_GEN_LFSR_EN is defined; otherwise mode 1 increments.
module stream_pattern_gen
  import stream_gen_pkg::*;
#(
  parameter int           W    = 8,
  parameter int           CH   = 4,
  parameter int           LEN  = 16,
  parameter logic [W-1:0] SEED = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [$clog2(LEN+1)-1:0]   burst_len,
  output logic                       busy,
  output logic                       done,
  stream_if.master                   intf
);

  localparam int LW = $clog2(LEN + 1);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  state_e        state, state_nxt;
  mode_e         mode_q;
  logic [LW-1:0] len_q, beat_q, len_clamp;
  logic [CW-1:0] chan_q;
  logic [W-1:0]  cnt_q [CH];
  logic [W-1:0]  pattern;
  logic          launch, accept, beat_last, chan_last;

  assign len_clamp = (burst_len > LW'(LEN)) ? LW'(LEN) : burst_len;
  assign launch    = (state == S_IDLE) && start;
  assign accept    = (state == S_RUN) && intf.ready;
  assign beat_last = (beat_q == len_q - LW'(1));
  assign chan_last = (chan_q == CW'(CH - 1));

`ifdef STREAM_PATTERN_GEN_LFSR_EN
  logic [W-1:0] lfsr_val;

  stream_pattern_lfsr #(.W(W), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (launch),
    .advance (accept),
    .value   (lfsr_val)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (len_clamp == '0) ? S_DONE : S_RUN;
      S_RUN:   if (accept && beat_last && chan_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters move only on acceptance, which keeps the offered beat stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      beat_q <= '0;
      chan_q <= '0;
      mode_q <= MODE_INC;
      for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
    end else if (launch) begin
      len_q  <= len_clamp;
      beat_q <= '0;
      chan_q <= '0;
      mode_q <= mode_e'(mode);
      for (int c = 0; c < CH; c++) cnt_q[c] <= W'(c);
    end else if (accept) begin
      cnt_q[chan_q] <= cnt_q[chan_q] + W'(1);
      if (beat_last) begin
        beat_q <= '0;
        chan_q <= chan_last ? '0 : chan_q + CW'(1);
      end else begin
        beat_q <= beat_q + LW'(1);
      end
    end
  end

  always_comb begin
    case (mode_q)
      MODE_INC:  pattern = cnt_q[chan_q];
`ifdef STREAM_PATTERN_GEN_LFSR_EN
      MODE_LFSR: pattern = lfsr_val;
`else
      MODE_LFSR: pattern = cnt_q[chan_q];
`endif
      default:   pattern = {(W / 8){8'hA5}};
    endcase
  end

  always_comb begin
    busy       = (state == S_RUN);
    done       = (state == S_DONE);
    intf.valid = (state == S_RUN);
    intf.data  = (state == S_RUN) ? pattern : '0;
    intf.chan  = (state == S_RUN) ? chan_q : '0;
    intf.last  = (state == S_RUN) && beat_last;
  end

endmodule
